// File: rtl/fusion_alu_pkg.sv
// Shared definitions for the sequential Fusion ALU: opcode constants,
// controller state encoding, iterative-unit modes and the flag bundle.
package fusion_alu_pkg;

   localparam logic [6:0] OPC_ALU = 7'h00;

   localparam logic [5:0] AR_NOP   = 6'd0;
   localparam logic [5:0] AR_ADD   = 6'd1;
   localparam logic [5:0] AR_SUB   = 6'd2;
   localparam logic [5:0] AR_AND   = 6'd3;
   localparam logic [5:0] AR_OR    = 6'd4;
   localparam logic [5:0] AR_XOR   = 6'd5;
   localparam logic [5:0] AR_SLL   = 6'd6;
   localparam logic [5:0] AR_SRL   = 6'd7;
   localparam logic [5:0] AR_SRA   = 6'd8;
   localparam logic [5:0] AR_SLT   = 6'd9;
   localparam logic [5:0] AR_SLTU  = 6'd10;
   localparam logic [5:0] AR_MUL   = 6'd11;
   localparam logic [5:0] AR_MULHU = 6'd12;
   localparam logic [5:0] AR_DIVU  = 6'd13;
   localparam logic [5:0] AR_REMU  = 6'd14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      MD_MUL   = 2'd0,
      MD_MULHU = 2'd1,
      MD_DIVU  = 2'd2,
      MD_REMU  = 2'd3
   } md_mode_e;

   typedef struct packed {
      logic carry;
      logic zero;
      logic neg;
      logic ovf;
      logic dz;
      logic illegal;
   } alu_flags_t;

endpackage

// File: rtl/fusion_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing
// a single hi/lo register pair; done is raised alongside the final step.
module fusion_muldiv_iter
   import fusion_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  md_mode_e         mode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   md_mode_e         mode_q, mode_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [WIDTH:0]   mul_sum, div_shift;
   logic             is_div, start_div, last;

   assign is_div    = (mode_q == MD_DIVU) || (mode_q == MD_REMU);
   assign start_div = (mode == MD_DIVU) || (mode == MD_REMU);
   assign last      = (cnt_q == CW'(WIDTH - 1));
   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
   assign div_shift = {hi_q, lo_q[WIDTH-1]};

   // Multiply: hi accumulates, lo holds the remaining multiplier bits.
   // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      mode_d = mode_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      opnd_d = opnd_q;
      if (start) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         mode_d = mode;
         hi_d   = '0;
         lo_d   = start_div ? op_a : op_b;
         opnd_d = start_div ? op_b : op_a;
      end else if (busy_q) begin
         if (is_div) begin
            if (div_shift >= {1'b0, opnd_q}) begin
               hi_d = WIDTH'(div_shift - {1'b0, opnd_q});
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = div_shift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
         end
         cnt_d = cnt_q + CW'(1);
         if (last) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         mode_q <= MD_MUL;
         hi_q   <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         mode_q <= mode_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         opnd_q <= opnd_d;
      end
   end

   assign busy   = busy_q;
   assign done   = busy_q && last;
   assign result = (mode_q == MD_MULHU || mode_q == MD_REMU) ? hi_d : lo_d;

endmodule

// File: rtl/fusion_alu_seq.sv
// Sequential ALU with valid/ready handshake: single-cycle ops computed here,
// multiply/divide delegated to fusion_muldiv_iter, result held until consumed.
module fusion_alu_seq
   import fusion_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       op_code,
   input  logic [5:0]       ar_code,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             flag_carry,
   output logic             flag_zero,
   output logic             flag_neg,
   output logic             flag_ovf,
   output logic             flag_dz,
   output logic             flag_illegal
);

   localparam int SHW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d, alu_res, md_result;
   alu_flags_t       flags_q, flags_d;
   logic [WIDTH:0]   add_sum, sub_diff;
   logic [SHW-1:0]   shamt;
   md_mode_e         md_mode;
   logic             accept, illegal, is_muldiv, is_div, div_zero;
   logic             alu_carry, alu_ovf, md_start, md_busy, md_done, load;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign accept    = in_valid && in_ready;
   assign illegal   = (op_code != OPC_ALU) || (ar_code > AR_REMU);
   assign is_muldiv = !illegal && (ar_code >= AR_MUL);
   assign is_div    = (ar_code == AR_DIVU) || (ar_code == AR_REMU);
   assign div_zero  = (op_b == '0);
   assign md_start  = accept && is_muldiv && !(is_div && div_zero);
   assign shamt     = op_b[SHW-1:0];
   assign add_sum   = {1'b0, op_a} + {1'b0, op_b};
   assign sub_diff  = {1'b0, op_a} - {1'b0, op_b};

   always_comb begin
      md_mode = MD_MUL;
      case (ar_code)
         AR_MULHU: md_mode = MD_MULHU;
         AR_DIVU:  md_mode = MD_DIVU;
         AR_REMU:  md_mode = MD_REMU;
         default:  md_mode = MD_MUL;
      endcase
   end

   // DIVU/REMU values here only matter for the divide-by-zero shortcut.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (ar_code)
         AR_ADD: begin
            alu_res   = add_sum[WIDTH-1:0];
            alu_carry = add_sum[WIDTH];
            alu_ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         AR_SUB: begin
            alu_res   = sub_diff[WIDTH-1:0];
            alu_carry = sub_diff[WIDTH];
            alu_ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         AR_AND:  alu_res = op_a & op_b;
         AR_OR:   alu_res = op_a | op_b;
         AR_XOR:  alu_res = op_a ^ op_b;
         AR_SLL:  alu_res = op_a << shamt;
         AR_SRL:  alu_res = op_a >> shamt;
         AR_SRA:  alu_res = $signed(op_a) >>> shamt;
         AR_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         AR_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
         AR_DIVU: alu_res = '1;
         AR_REMU: alu_res = op_a;
         default: alu_res = '0;
      endcase
   end

   // Outputs and flags only change when a result is loaded; otherwise they hold.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      flags_d = flags_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (md_start) begin
                  state_d = is_div ? ST_DIV : ST_MUL;
               end else begin
                  state_d         = ST_DONE;
                  load            = 1'b1;
                  out_d           = illegal ? '0 : alu_res;
                  flags_d.carry   = !illegal && alu_carry;
                  flags_d.ovf     = !illegal && alu_ovf;
                  flags_d.dz      = !illegal && is_div && div_zero;
                  flags_d.illegal = illegal;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            if (md_done) begin
               state_d = ST_DONE;
               load    = 1'b1;
               out_d   = md_result;
               flags_d = '0;
            end else if (!md_busy) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         flags_d.zero = (out_d == '0);
         flags_d.neg  = out_d[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         out_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         flags_q <= flags_d;
      end
   end

   fusion_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .mode   (md_mode),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   assign out          = out_q;
   assign flag_carry   = flags_q.carry;
   assign flag_zero    = flags_q.zero;
   assign flag_neg     = flags_q.neg;
   assign flag_ovf     = flags_q.ovf;
   assign flag_dz      = flags_q.dz;
   assign flag_illegal = flags_q.illegal;

endmodule

// File: tb/tb_fusion_alu_seq.sv
// Scoreboard bench for fusion_alu_seq: directed vectors push expected results,
// a negedge monitor pops and compares on every out_valid/out_ready handshake.
module tb_fusion_alu_seq;
   import fusion_alu_pkg::*;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst, in_valid, in_ready, out_valid, out_ready;
   logic [6:0]       op_code;
   logic [5:0]       ar_code;
   logic [WIDTH-1:0] op_a, op_b, out;
   logic             flag_carry, flag_zero, flag_neg, flag_ovf, flag_dz, flag_illegal;
   logic [5:0]       act_flags;

   typedef struct {
      logic [31:0] out;
      logic [5:0]  flags;
      string       name;
   } exp_t;

   exp_t expQ[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   assign act_flags = {flag_carry, flag_zero, flag_neg, flag_ovf, flag_dz, flag_illegal};

   fusion_alu_seq #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .op_code      (op_code),
      .ar_code      (ar_code),
      .op_a         (op_a),
      .op_b         (op_b),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out          (out),
      .flag_carry   (flag_carry),
      .flag_zero    (flag_zero),
      .flag_neg     (flag_neg),
      .flag_ovf     (flag_ovf),
      .flag_dz      (flag_dz),
      .flag_illegal (flag_illegal)
   );

   // flags packed as {carry, zero, neg, ovf, dz, illegal}
   function automatic logic [5:0] fl(input logic c, input logic z, input logic n,
                                     input logic o, input logic d, input logic i);
      return {c, z, n, o, d, i};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result: got 0x%08h, expected no result", out);
         end else begin
            mon_e = expQ.pop_front();
            checkOutput({mon_e.name, " out"}, out, mon_e.out);
            checkOutput({mon_e.name, " flags"}, {26'd0, act_flags}, {26'd0, mon_e.flags});
         end
      end
   end

   task automatic applyStimulus(input string name, input logic [6:0] opc, input logic [5:0] ar,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp_out, input logic [5:0] exp_fl,
                                input int exp_lat, input int hold);
      int budget, lat, ready_hi;
      exp_t e;
      budget = 0;
      while (!in_ready && budget < 200) begin
         @(posedge clk);
         #1;
         budget++;
      end
      checkOutput({name, " in_ready before issue"}, {31'd0, in_ready}, 32'd1);
      if (hold > 0) out_ready = 1'b0;
      e.out   = exp_out;
      e.flags = exp_fl;
      e.name  = name;
      expQ.push_back(e);
      op_code  = opc;
      ar_code  = ar;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_a     = $urandom;
      op_b     = $urandom;
      ar_code  = 6'($urandom);
      op_code  = 7'($urandom);
      lat      = 0;
      ready_hi = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid && in_ready) ready_hi++;
      end while (!out_valid && lat < 100);
      checkOutput({name, " latency"}, lat, exp_lat);
      checkOutput({name, " in_ready while busy"}, ready_hi, 32'd0);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         checkOutput({name, " held out"}, out, exp_out);
         checkOutput({name, " held in_ready"}, {31'd0, in_ready}, 32'd0);
         checkOutput({name, " held out_valid"}, {31'd0, out_valid}, 32'd1);
      end
      if (hold > 0) begin
         @(posedge clk);
         #1;
         out_ready = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int seen, budget;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op_code   = '0;
      ar_code   = '0;
      op_a      = '0;
      op_b      = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("reset out", out, 32'd0);
      checkOutput("reset flags", {26'd0, act_flags}, 32'd0);

      applyStimulus("nop", OPC_ALU, AR_NOP, 32'd5, 32'd9, 32'd0, fl(0,1,0,0,0,0), 1, 0);
      applyStimulus("add_ovf", OPC_ALU, AR_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, fl(0,0,1,1,0,0), 1, 0);
      applyStimulus("add_carry", OPC_ALU, AR_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, fl(1,1,0,0,0,0), 1, 0);
      applyStimulus("sub_borrow", OPC_ALU, AR_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, fl(1,0,1,0,0,0), 1, 0);
      applyStimulus("sub_ovf", OPC_ALU, AR_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF, fl(0,0,0,1,0,0), 1, 0);
      applyStimulus("and", OPC_ALU, AR_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, fl(0,0,0,0,0,0), 1, 0);
      applyStimulus("or", OPC_ALU, AR_OR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, fl(0,0,1,0,0,0), 1, 0);
      applyStimulus("xor_backpressure", OPC_ALU, AR_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, fl(0,0,1,0,0,0), 1, 5);
      applyStimulus("sra", OPC_ALU, AR_SRA, 32'h80000000, 32'd4, 32'hF8000000, fl(0,0,1,0,0,0), 1, 0);
      applyStimulus("sll_mask", OPC_ALU, AR_SLL, 32'd1, 32'h21, 32'd2, fl(0,0,0,0,0,0), 1, 0);
      applyStimulus("srl", OPC_ALU, AR_SRL, 32'h80000000, 32'd31, 32'd1, fl(0,0,0,0,0,0), 1, 0);
      applyStimulus("sra_zero", OPC_ALU, AR_SRA, 32'h12345678, 32'h20, 32'h12345678, fl(0,0,0,0,0,0), 1, 0);
      applyStimulus("slt", OPC_ALU, AR_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, fl(0,0,0,0,0,0), 1, 0);
      applyStimulus("sltu", OPC_ALU, AR_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, fl(0,1,0,0,0,0), 1, 0);
      applyStimulus("mul", OPC_ALU, AR_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, fl(0,0,1,0,0,0), 33, 0);
      applyStimulus("mulhu", OPC_ALU, AR_MULHU, 32'hFFFFFFFF, 32'd2, 32'd1, fl(0,0,0,0,0,0), 33, 0);
      applyStimulus("mul_low_zero", OPC_ALU, AR_MUL, 32'h00010000, 32'h00010000, 32'd0, fl(0,1,0,0,0,0), 33, 0);
      applyStimulus("mulhu_2p32", OPC_ALU, AR_MULHU, 32'h00010000, 32'h00010000, 32'd1, fl(0,0,0,0,0,0), 33, 0);
      applyStimulus("divu", OPC_ALU, AR_DIVU, 32'd100, 32'd7, 32'd14, fl(0,0,0,0,0,0), 33, 0);
      applyStimulus("remu", OPC_ALU, AR_REMU, 32'd100, 32'd7, 32'd2, fl(0,0,0,0,0,0), 33, 0);
      applyStimulus("divu_big", OPC_ALU, AR_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, fl(0,0,0,0,0,0), 33, 0);
      applyStimulus("remu_big", OPC_ALU, AR_REMU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, fl(0,0,0,0,0,0), 33, 0);
      applyStimulus("divu_by0", OPC_ALU, AR_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, fl(0,0,1,0,1,0), 1, 0);
      applyStimulus("remu_by0", OPC_ALU, AR_REMU, 32'd5, 32'd0, 32'd5, fl(0,0,0,0,1,0), 1, 0);
      applyStimulus("illegal_opc", 7'h13, AR_ADD, 32'h7FFFFFFF, 32'd1, 32'd0, fl(0,1,0,0,0,1), 1, 0);
      applyStimulus("illegal_ar15", OPC_ALU, 6'd15, 32'd3, 32'd4, 32'd0, fl(0,1,0,0,0,1), 1, 0);
      applyStimulus("illegal_ar63", OPC_ALU, 6'd63, 32'd3, 32'd4, 32'd0, fl(0,1,0,0,0,1), 1, 0);
      applyStimulus("sub_after_illegal", OPC_ALU, AR_SUB, 32'd10, 32'd3, 32'd7, fl(0,0,0,0,0,0), 1, 0);

      // Abort a multiply with reset; no result may ever appear for it.
      budget = 0;
      while (!in_ready && budget < 200) begin
         @(posedge clk);
         #1;
         budget++;
      end
      op_code  = OPC_ALU;
      ar_code  = AR_MUL;
      op_a     = 32'd3;
      op_b     = 32'd5;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("abort out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("abort out cleared", out, 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkOutput("abort no result", seen, 32'd0);

      applyStimulus("add_after_abort", OPC_ALU, AR_ADD, 32'd2, 32'd3, 32'd5, fl(0,0,0,0,0,0), 1, 0);

      budget = 0;
      while (expQ.size() != 0 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      checkOutput("scoreboard drained", expQ.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
